libhdl_ocmem_arb2: RTL and testbench
====================================

// Module: libhdl_ocmem_arb2
// PURPOSE
//  Two-requester round-robin arbiter that shares one port of an on-chip memory (ocmem).
//  Each requester issues a valid/ready command: read or write, with address and data.
//  Accepted commands are registered onto the memory port. Read data returns on the
//  granted requester's response port after a fixed latency; writes get no response.
//  Sits between two masters (e.g. DMA and CPU) and port A or B of the dual-port ocmem.
// PARAMETERS
//  W      32    data width
//  D      1024  memory depth in words; address width AW = $clog2(D)
//  RDLAT  1     memory read latency in cycles (1 = no output reg, 2 = OREG=1); legal 1..2
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   synchronous reset, active high
//  i_req0_valid   in   1   requester 0 command valid
//  o_req0_ready   out  1   requester 0 command accepted this cycle
//  i_req0_we      in   1   requester 0 write (1) / read (0)
//  i_req0_addr    in   AW  requester 0 address
//  i_req0_wdata   in   W   requester 0 write data
//  o_rsp0_valid   out  1   requester 0 read data valid (single-cycle pulse)
//  o_rsp0_rdata   out  W   requester 0 read data
//  i_req1_*, o_req1_ready, o_rsp1_*  same as requester 0, for requester 1
//  o_mem_we       out  1   memory write enable
//  o_mem_addr     out  AW  memory address
//  o_mem_wdata    out  W   memory write data
//  i_mem_rdata    in   W   memory read data (valid RDLAT cycles after o_mem_addr)
// BEHAVIOUR
//  Reset (i_rst=1 at an edge): registered outputs go to 0 on that edge.
//   - o_mem_we/addr/wdata = 0; tag pipeline cleared; last-grant pointer = 1.
//   - o_reqN_ready = 0 while i_rst=1.
//  Arbitration (combinational, each cycle):
//   - Only one valid: that requester is granted.
//   - Both valid: grant the requester that is not the last-grant pointer.
//   - First tie after reset goes to requester 0.
//   - o_reqN_ready = grantN; ready may depend on valid.
//   - At most one ready is high per cycle; neither is high when no valid is high.
//   - Pointer updates only on an accepted command (valid & ready).
//  Handshake: a command is transferred when valid & ready at a rising edge.
//   - A requester holds valid and payload stable until ready.
//   - A requester may deassert valid without being granted; no penalty.
//  Command stage, accept at edge T:
//   - o_mem_we/addr/wdata hold that command during cycle T+1.
//   - No accept: o_mem_we=0; addr and wdata hold their previous values.
//  Response tracking:
//   - Each accepted read pushes {valid=1, id} into a shift pipe of depth RDLAT+1.
//   - Writes and idle cycles push valid=0.
//   - Pipe output drives o_rspN_valid for id==N; o_rspN_rdata = i_mem_rdata.
//   - Timing: a read accepted at edge T gives o_rsp valid during cycle T+1+RDLAT.
//   - rdata is passed through unregistered (no extra latency).
//   - o_rsp0_valid and o_rsp1_valid are never high together.
//  Throughput: one command per cycle with no bubbles; back-to-back accepts allowed.
//  Ordering:
//   - Commands reach memory in accept order.
//   - A read accepted after a write to the same address returns the new data.
//   - Memory read mode (READ_FIRST/WRITE_FIRST) is irrelevant: writes get no response.
//  Reset mid-operation:
//   - In-flight reads are dropped; no o_rsp pulse after the reset edge.
//   - Requesters must reissue dropped reads.
//  Address range: addresses >= D are passed through unchecked; behaviour is the memory's.
// TESTING
//  1 Write: req0 we=1 addr=5 wdata=0xA5A5A5A5, then read addr 5 (RDLAT=1).
//    -> o_rsp0_valid pulses exactly 2 cycles after the read accept, rdata=0xA5A5A5A5.
//    -> o_rsp1_valid stays 0.
//  2 Both requesters hold valid reads for 6 cycles after reset.
//    -> grants go 0,1,0,1,0,1; each read's rsp appears on its own port in the same order.
//  3 req1 alone for 3 accepts, then both valid.
//    -> next grant is 0, then 1; ready is never high on both ports.
//  4 req0 writes addr 9 = 0x1234 at T; req1 reads addr 9 accepted at T+1.
//    -> o_rsp1_rdata = 0x1234.
//  5 RDLAT=2 build, single read accepted at T.
//    -> o_rsp valid in cycle T+3 only; data matches memory content.
//  6 i_rst pulsed with 2 reads in flight.
//    -> no o_rsp pulses afterwards; o_mem_we=0; first tie after release grants 0.

Source files
------------

// File: rtl/libhdl_ocmem_arb2.sv
`default_nettype none
// ============================================================================
// Module      : libhdl_ocmem_arb2
// Description : Two-requester round-robin arbiter that shares one port of an
//               on-chip memory. Each requester issues valid/ready commands
//               (read or write). The accepted command is registered onto the
//               memory port. Read data is routed back to the requester that
//               issued the read, a fixed RDLAT cycles after the memory sees
//               the address. Writes get no response.
// Parameters  : W      data width
//               D      memory depth in words (address width = $clog2(D))
//               RDLAT  memory read latency in cycles, 1..2
// Ports       : i_clk / i_rst                  clock, synchronous active-high reset
//               i_reqN_valid / o_reqN_ready    command handshake, requester N
//               i_reqN_we/_addr/_wdata         command payload, requester N
//               o_rspN_valid / o_rspN_rdata    read response, requester N
//               o_mem_we/_addr/_wdata          registered memory command
//               i_mem_rdata                    memory read data
// Revision    : 1.0  initial release
// ============================================================================
module libhdl_ocmem_arb2 #(
    parameter int W     = 32,
    parameter int D     = 1024,
    parameter int RDLAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,

    // requester 0
    input  logic                 i_req0_valid,
    output logic                 o_req0_ready,
    input  logic                 i_req0_we,
    input  logic [$clog2(D)-1:0] i_req0_addr,
    input  logic [W-1:0]         i_req0_wdata,
    output logic                 o_rsp0_valid,
    output logic [W-1:0]         o_rsp0_rdata,

    // requester 1
    input  logic                 i_req1_valid,
    output logic                 o_req1_ready,
    input  logic                 i_req1_we,
    input  logic [$clog2(D)-1:0] i_req1_addr,
    input  logic [W-1:0]         i_req1_wdata,
    output logic                 o_rsp1_valid,
    output logic [W-1:0]         o_rsp1_rdata,

    // memory port
    output logic                 o_mem_we,
    output logic [$clog2(D)-1:0] o_mem_addr,
    output logic [W-1:0]         o_mem_wdata,
    input  logic [W-1:0]         i_mem_rdata
);

    localparam int c_AW   = $clog2(D);
    // One stage covers the command register, RDLAT more cover the memory.
    localparam int c_PIPE = RDLAT + 1;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              w_cmd_we;
    logic [c_AW-1:0]   w_cmd_addr;
    logic [W-1:0]      w_cmd_wdata;
    logic              w_push_vld;
    logic              w_push_id;

    // Identity of the requester granted most recently (1 = requester 1).
    // Resets to 1 so that the first tie after reset goes to requester 0.
    logic              r_last_grant;

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!i_rst) begin
            if (i_req0_valid && i_req1_valid) begin
                // Tie: the requester that was not served last wins.
                w_grant0 = r_last_grant;
                w_grant1 = ~r_last_grant;
            end else begin
                w_grant0 = i_req0_valid;
                w_grant1 = i_req1_valid;
            end
        end
    end

    // A grant is only ever given to a valid requester, so a grant is an accept.
    assign w_accept     = w_grant0 | w_grant1;
    assign o_req0_ready = w_grant0;
    assign o_req1_ready = w_grant1;

    // Payload of the granted requester.
    assign w_cmd_we    = w_grant1 ? i_req1_we    : i_req0_we;
    assign w_cmd_addr  = w_grant1 ? i_req1_addr  : i_req0_addr;
    assign w_cmd_wdata = w_grant1 ? i_req1_wdata : i_req0_wdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant1;
        end
    end

    // ------------------------------------------------------------------------
    // Command register onto the memory port
    // ------------------------------------------------------------------------
    logic              r_mem_we;
    logic [c_AW-1:0]   r_mem_addr;
    logic [W-1:0]      r_mem_wdata;

    // Address and data are only reloaded on an accept; in idle cycles they
    // keep their last values so the memory inputs do not toggle needlessly.
    // The write enable is cleared every idle cycle so no write is repeated.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_mem_we    <= w_cmd_we;
            r_mem_addr  <= w_cmd_addr;
            r_mem_wdata <= w_cmd_wdata;
        end else begin
            r_mem_we    <= 1'b0;
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------------
    // Response tag pipeline
    // ------------------------------------------------------------------------
    // Every cycle pushes one tag: a read accept pushes valid=1 with the
    // requester id, anything else pushes valid=0. The tag leaves the last
    // stage exactly when the memory presents the matching read data, so the
    // data itself can be forwarded combinationally.
    logic [c_PIPE-1:0] r_tag_vld;
    logic [c_PIPE-1:0] r_tag_id;
    logic              w_rsp_vld;
    logic              w_rsp_id;

    assign w_push_vld = w_accept & ~w_cmd_we;
    assign w_push_id  = w_grant1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Dropping in-flight tags guarantees no response after reset.
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_push_vld;
            r_tag_id[0]  <= w_push_id;
            for (int i = 1; i < c_PIPE; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    assign w_rsp_vld = r_tag_vld[c_PIPE-1];
    assign w_rsp_id  = r_tag_id[c_PIPE-1];

    // A single tag stream feeds both ports, so the two valids are exclusive.
    assign o_rsp0_valid = w_rsp_vld & ~w_rsp_id;
    assign o_rsp1_valid = w_rsp_vld &  w_rsp_id;
    assign o_rsp0_rdata = i_mem_rdata;
    assign o_rsp1_rdata = i_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_libhdl_ocmem_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_libhdl_ocmem_arb2
// Description : Self-checking bench for libhdl_ocmem_arb2. Two instances
//               (RDLAT=1 and RDLAT=2) share the same stimulus; each has its
//               own behavioural memory. A transaction-level reference model
//               (round-robin rule, shadow memory, per-accept response record)
//               predicts readies, memory port and responses every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_libhdl_ocmem_arb2;

    localparam int W    = 32;
    localparam int D    = 1024;
    localparam int AW   = 10;
    localparam int MAXE = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus
    logic          rst;
    logic          v0, we0, v1, we1;
    logic [AW-1:0] a0, a1;
    logic [W-1:0]  d0, d1;

    // instance with RDLAT=1
    logic          a_rdy0, a_rdy1, a_rv0, a_rv1, a_mwe;
    logic [W-1:0]  a_rd0, a_rd1, a_mwd, a_mrd;
    logic [AW-1:0] a_maddr;
    // instance with RDLAT=2
    logic          b_rdy0, b_rdy1, b_rv0, b_rv1, b_mwe;
    logic [W-1:0]  b_rd0, b_rd1, b_mwd, b_mrd;
    logic [AW-1:0] b_maddr;

    libhdl_ocmem_arb2 #(.W(W), .D(D), .RDLAT(1)) u_dut_l1 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(a_rdy0), .i_req0_we(we0),
        .i_req0_addr(a0), .i_req0_wdata(d0),
        .o_rsp0_valid(a_rv0), .o_rsp0_rdata(a_rd0),
        .i_req1_valid(v1), .o_req1_ready(a_rdy1), .i_req1_we(we1),
        .i_req1_addr(a1), .i_req1_wdata(d1),
        .o_rsp1_valid(a_rv1), .o_rsp1_rdata(a_rd1),
        .o_mem_we(a_mwe), .o_mem_addr(a_maddr), .o_mem_wdata(a_mwd),
        .i_mem_rdata(a_mrd)
    );

    libhdl_ocmem_arb2 #(.W(W), .D(D), .RDLAT(2)) u_dut_l2 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(b_rdy0), .i_req0_we(we0),
        .i_req0_addr(a0), .i_req0_wdata(d0),
        .o_rsp0_valid(b_rv0), .o_rsp0_rdata(b_rd0),
        .i_req1_valid(v1), .o_req1_ready(b_rdy1), .i_req1_we(we1),
        .i_req1_addr(a1), .i_req1_wdata(d1),
        .o_rsp1_valid(b_rv1), .o_rsp1_rdata(b_rd1),
        .o_mem_we(b_mwe), .o_mem_addr(b_maddr), .o_mem_wdata(b_mwd),
        .i_mem_rdata(b_mrd)
    );

    // behavioural synchronous memories (contents start at zero)
    bit [W-1:0] mem_a [D];
    bit [W-1:0] mem_b [D];
    bit [W-1:0] a_q1;
    bit [W-1:0] b_q1, b_q2;

    always @(posedge clk) begin
        if (a_mwe) mem_a[a_maddr] <= a_mwd;
        a_q1 <= mem_a[a_maddr];
    end
    always @(posedge clk) begin
        if (b_mwe) mem_b[b_maddr] <= b_mwd;
        b_q1 <= mem_b[b_maddr];
        b_q2 <= b_q1;
    end
    assign a_mrd = a_q1;
    assign b_mrd = b_q2;

    // ------------------------------------------------------------------------
    // reference model state
    // ------------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    int          edge_n;
    int          last_rst_edge;
    int          last_acc;          // requester accepted at the latest edge, -1 none
    bit          lastg;             // requester served most recently
    bit          exp_we;
    bit [AW-1:0] exp_addr;
    bit [W-1:0]  exp_wd;
    bit [W-1:0]  shadow [D];
    bit          acc_rd   [MAXE];
    bit          acc_id   [MAXE];
    bit [W-1:0]  acc_data [MAXE];
    int          dut_glog [$];      // grants observed on the RDLAT=1 instance

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // round-robin rule: single valid wins; on a tie the one not served last wins
    function automatic int model_grant();
        if (rst)      return -1;
        if (v0 && v1) return (lastg == 1'b1) ? 0 : 1;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    task automatic check_rsp(input int L, input string nm,
                             input logic rv0, input logic rv1,
                             input logic [W-1:0] rd0, input logic [W-1:0] rd1);
        int k;
        bit ev;
        bit eid;
        k   = edge_n - L;
        ev  = (k >= 0) && (k > last_rst_edge) && acc_rd[k];
        eid = (k >= 0) ? acc_id[k] : 1'b0;
        chk({nm, "_rsp0_valid"}, 64'(rv0), 64'(ev && !eid));
        chk({nm, "_rsp1_valid"}, 64'(rv1), 64'(ev && eid));
        if (ev && !eid) chk({nm, "_rsp0_rdata"}, 64'(rd0), 64'(acc_data[k]));
        if (ev && eid)  chk({nm, "_rsp1_rdata"}, 64'(rd1), 64'(acc_data[k]));
    endtask

    task automatic check_outputs();
        int g;
        g = model_grant();
        chk("l1_ready0", 64'(a_rdy0), 64'(g == 0));
        chk("l1_ready1", 64'(a_rdy1), 64'(g == 1));
        chk("l2_ready0", 64'(b_rdy0), 64'(g == 0));
        chk("l2_ready1", 64'(b_rdy1), 64'(g == 1));
        chk("l1_mem_we",    64'(a_mwe),   64'(exp_we));
        chk("l1_mem_addr",  64'(a_maddr), 64'(exp_addr));
        chk("l1_mem_wdata", 64'(a_mwd),   64'(exp_wd));
        chk("l2_mem_we",    64'(b_mwe),   64'(exp_we));
        chk("l2_mem_addr",  64'(b_maddr), 64'(exp_addr));
        chk("l2_mem_wdata", 64'(b_mwd),   64'(exp_wd));
        check_rsp(1, "l1", a_rv0, a_rv1, a_rd0, a_rd1);
        check_rsp(2, "l2", b_rv0, b_rv1, b_rd0, b_rd1);
        if (a_rdy0 || a_rdy1) dut_glog.push_back(a_rdy1 ? 1 : 0);
    endtask

    task automatic update_model();
        int          g;
        bit          we;
        bit [AW-1:0] ad;
        bit [W-1:0]  wd;
        g = model_grant();
        edge_n++;
        acc_rd[edge_n] = 1'b0;
        last_acc = -1;
        if (rst) begin
            lastg         = 1'b1;
            exp_we        = 1'b0;
            exp_addr      = '0;
            exp_wd        = '0;
            last_rst_edge = edge_n;
        end else if (g >= 0) begin
            we = (g == 1) ? we1 : we0;
            ad = (g == 1) ? a1  : a0;
            wd = (g == 1) ? d1  : d0;
            lastg    = (g == 1);
            last_acc = g;
            exp_we   = we;
            exp_addr = ad;
            exp_wd   = wd;
            if (we) begin
                shadow[ad] = wd;
            end else begin
                acc_rd[edge_n]   = 1'b1;
                acc_id[edge_n]   = (g == 1);
                acc_data[edge_n] = shadow[ad];
            end
        end else begin
            exp_we = 1'b0;
        end
    endtask

    // one clock: check during the cycle, then advance the model at the edge
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle_steps(input int n);
        v0 = 1'b0;
        v1 = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int base;
        rst = 1'b1;
        v0 = 1'b1; we0 = 1'b0; a0 = '0; d0 = '0;
        v1 = 1'b1; we1 = 1'b0; a1 = '0; d1 = '0;
        @(posedge clk);
        #1;
        edge_n = 0; last_rst_edge = 0; last_acc = -1;
        lastg = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;

        // reset held with both valids high: readies must stay low
        step();
        step();
        rst = 1'b0;

        // write addr 5 then read it back on requester 0
        v1 = 1'b0;
        v0 = 1'b1; we0 = 1'b1; a0 = AW'(5); d0 = 32'hA5A5_A5A5;
        step();
        we0 = 1'b0;
        step();
        idle_steps(4);

        // both requesters issue reads continuously: strict alternation from 0
        rst = 1'b1; step(); rst = 1'b0;
        base = dut_glog.size();
        for (int i = 0; i < 6; i++) begin
            v0 = 1'b1; we0 = 1'b0; a0 = AW'(5 + i);
            v1 = 1'b1; we1 = 1'b0; a1 = AW'(20 + i);
            step();
        end
        for (int i = 0; i < 6; i++) chk("alt_grant", 64'(dut_glog[base + i]), 64'(i % 2));
        idle_steps(4);

        // requester 1 alone for three accepts, then a tie goes to 0, then 1
        base = dut_glog.size();
        v0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v1 = 1'b1; we1 = 1'b0; a1 = AW'(i); step();
        end
        v0 = 1'b1; we0 = 1'b0; a0 = AW'(7);
        step();
        v0 = 1'b0;
        step();
        chk("solo_grant0", 64'(dut_glog[base + 0]), 64'd1);
        chk("solo_grant1", 64'(dut_glog[base + 1]), 64'd1);
        chk("solo_grant2", 64'(dut_glog[base + 2]), 64'd1);
        chk("tie_grant_a", 64'(dut_glog[base + 3]), 64'd0);
        chk("tie_grant_b", 64'(dut_glog[base + 4]), 64'd1);
        idle_steps(4);

        // write on 0 then read of the same address on 1 one cycle later
        v0 = 1'b1; we0 = 1'b1; a0 = AW'(9); d0 = 32'h0000_1234;
        v1 = 1'b1; we1 = 1'b0; a1 = AW'(9);
        step();
        v0 = 1'b0;
        step();
        idle_steps(4);

        // reset with two reads in flight, then a tie must go to 0
        v0 = 1'b1; we0 = 1'b0; a0 = AW'(5);
        v1 = 1'b1; we1 = 1'b0; a1 = AW'(9);
        step();
        step();
        v0 = 1'b0; v1 = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        base = dut_glog.size();
        v0 = 1'b1; we0 = 1'b0; a0 = AW'(1);
        v1 = 1'b1; we1 = 1'b0; a1 = AW'(2);
        step();
        chk("post_rst_tie", 64'(dut_glog[base]), 64'd0);
        idle_steps(4);

        // randomized traffic obeying the hold-until-ready rule
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (v0 && last_acc != 0) begin
                if ($urandom_range(0, 9) == 0) v0 = 1'b0;
            end else begin
                v0  = ($urandom_range(0, 9) < 6);
                we0 = 1'($urandom_range(0, 1));
                a0  = AW'($urandom_range(0, 15));
                d0  = $urandom;
            end
            if (v1 && last_acc != 1) begin
                if ($urandom_range(0, 9) == 0) v1 = 1'b0;
            end else begin
                v1  = ($urandom_range(0, 9) < 6);
                we1 = 1'($urandom_range(0, 1));
                a1  = AW'($urandom_range(0, 15));
                d1  = $urandom;
            end
            step();
        end
        rst = 1'b0;
        idle_steps(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
